// File: rtl/clock_pkg.sv
// clock_pkg
// Shared types and helpers for the multi-alarm clock.
//   alarm_state_e : per-channel alarm state (IDLE, RINGING, SNOOZED)
//   *_MAX         : binary upper limits of the BCD time fields
//   bcd_valid()   : both digits decimal and value within limit
//   bcd_inc()     : BCD increment with wrap at limit and carry out
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } alarm_state_e;

    localparam logic [7:0] HOUR_MAX = 8'd23;
    localparam logic [7:0] MIN_MAX  = 8'd59;
    localparam logic [7:0] SEC_MAX  = 8'd59;

    typedef struct packed {
        logic       carry;
        logic [7:0] val;
    } bcd_inc_t;

    function automatic logic [7:0] bcd_to_bin(input logic [7:0] v);
        return 8'(v[7:4]) * 8'd10 + 8'(v[3:0]);
    endfunction

    function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] limit);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (bcd_to_bin(v) <= limit);
    endfunction

    function automatic bcd_inc_t bcd_inc(input logic [7:0] v, input logic [7:0] limit);
        bcd_inc_t r;
        r.carry = 1'b0;
        if (bcd_to_bin(v) >= limit) begin
            r.val   = 8'h00;
            r.carry = 1'b1;
        end else if (v[3:0] >= 4'd9) begin
            r.val = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r.val = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// alarm_channel
// One alarm: stored hh:mm, ring/snooze/timeout state machine.
//   clk_i, rst_i          : clock, async active-high reset
//   en_i                  : alarm enable level; low forces IDLE
//   wr_load_i, wr_hour_i, wr_min_i : accepted write of hh:mm for this channel
//   tick_i                : time advanced this cycle (dropped ticks excluded)
//   next_hour_i/min_i/sec_i : time value being loaded at the coming edge
//   snooze_i, dismiss_i   : user pulses, shared by all channels
//   ringing_o, snoozed_o  : state flags
//
// state   | meaning
// IDLE    | armed or disabled, waiting for hh:mm:00
// RINGING | ringing, ring timer counting down to auto-stop
// SNOOZED | silent, snooze counter counting down to re-ring
module alarm_channel
    import clock_pkg::*;
#(
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned RING_SECS  = 60
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       wr_load_i,
    input  logic [7:0] wr_hour_i,
    input  logic [7:0] wr_min_i,
    input  logic       tick_i,
    input  logic [7:0] next_hour_i,
    input  logic [7:0] next_min_i,
    input  logic [7:0] next_sec_i,
    input  logic       snooze_i,
    input  logic       dismiss_i,
    output logic       ringing_o,
    output logic       snoozed_o
);
    localparam int unsigned RING_W = $clog2(RING_SECS + 1);
    localparam int unsigned SNZ_W  = $clog2(SNOOZE_MIN * 60 + 1);
    localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SECS);
    localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_MIN * 60);

    alarm_state_e      state_q, state_d;
    logic [7:0]        alm_hour_q, alm_hour_d, alm_min_q, alm_min_d;
    logic [RING_W-1:0] ring_q, ring_d;
    logic [SNZ_W-1:0]  snz_q, snz_d;
    logic              match;

    always_comb begin
        state_d    = state_q;
        alm_hour_d = alm_hour_q;
        alm_min_d  = alm_min_q;
        ring_d     = ring_q;
        snz_d      = snz_q;
        match      = tick_i && (next_hour_i == alm_hour_q) && (next_min_i == alm_min_q)
                     && (next_sec_i == 8'h00);
        if (wr_load_i) begin
            alm_hour_d = wr_hour_i;
            alm_min_d  = wr_min_i;
            state_d    = IDLE;
        end else if (!en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (match) begin
                        state_d = RINGING;
                        ring_d  = RING_LOAD;
                    end
                end
                RINGING: begin
                    if (dismiss_i) begin
                        state_d = IDLE;
                    end else if (snooze_i) begin
                        state_d = SNOOZED;
                        snz_d   = SNZ_LOAD;
                    end else if (tick_i) begin
                        if (ring_q <= RING_W'(1)) state_d = IDLE;
                        else                      ring_d  = ring_q - RING_W'(1);
                    end
                end
                SNOOZED: begin
                    if (dismiss_i) begin
                        state_d = IDLE;
                    end else if (tick_i) begin
                        if (snz_q <= SNZ_W'(1)) begin
                            state_d = RINGING;
                            ring_d  = RING_LOAD;
                            snz_d   = '0;
                        end else begin
                            snz_d = snz_q - SNZ_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // disabling also wins over a same-cycle write
        if (!en_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            alm_hour_q <= 8'h00;
            alm_min_q  <= 8'h00;
            ring_q     <= '0;
            snz_q      <= '0;
        end else begin
            state_q    <= state_d;
            alm_hour_q <= alm_hour_d;
            alm_min_q  <= alm_min_d;
            ring_q     <= ring_d;
            snz_q      <= snz_d;
        end
    end

    assign ringing_o = (state_q == RINGING);
    assign snoozed_o = (state_q == SNOOZED);

endmodule

// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock
// 24-hour BCD clock with NUM_ALARMS alarm channels and an hourly chime.
//   clk, rst                 : clock, async active-high reset
//   tick_1hz                 : one-cycle pulse per second
//   wr_valid, wr_target, wr_hour/min/sec : BCD write (0 = time, k = alarm k-1)
//   alarm_en                 : per-alarm enable level
//   snooze, dismiss          : user pulses
//   hour_bcd/min_bcd/sec_bcd : current time
//   ringing, ring_id         : any alarm ringing, lowest ringing index
//   snoozed                  : per-alarm snoozed flag
//   chime                    : hourly chime, masked while ringing
//   wr_ack, wr_err           : write accepted / rejected, one cycle after write
module multi_alarm_clock
    import clock_pkg::*;
#(
    parameter int unsigned NUM_ALARMS = 4,
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned RING_SECS  = 60,
    parameter int unsigned CHIME_SECS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_1hz,
    input  logic                  wr_valid,
    input  logic [3:0]            wr_target,
    input  logic [7:0]            wr_hour,
    input  logic [7:0]            wr_min,
    input  logic [7:0]            wr_sec,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic [7:0]            hour_bcd,
    output logic [7:0]            min_bcd,
    output logic [7:0]            sec_bcd,
    output logic                  ringing,
    output logic [3:0]            ring_id,
    output logic [NUM_ALARMS-1:0] snoozed,
    output logic                  chime,
    output logic                  wr_ack,
    output logic                  wr_err
);
    localparam int unsigned CHIME_W = $clog2(CHIME_SECS + 1);
    localparam logic [CHIME_W-1:0] CHIME_LOAD  = CHIME_W'(CHIME_SECS);
    localparam logic [3:0]         LAST_TARGET = 4'(NUM_ALARMS);

    logic [7:0]         hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic [CHIME_W-1:0] chime_cnt_q, chime_cnt_d;
    logic               wr_ack_q, wr_err_q;
    bcd_inc_t           sec_inc, min_inc, hour_inc;
    logic               day_wrap_unused;
    logic               wr_fields_ok, wr_time_ok, wr_alarm_ok, tick_adv, top_of_hour;
    logic [NUM_ALARMS-1:0] ring_vec;
    logic [3:0]         ring_id_c;
    logic               ring_found;

    always_comb begin
        sec_inc  = bcd_inc(sec_q, SEC_MAX);
        min_inc  = bcd_inc(min_q, MIN_MAX);
        hour_inc = bcd_inc(hour_q, HOUR_MAX);

        wr_fields_ok = bcd_valid(wr_hour, HOUR_MAX) && bcd_valid(wr_min, MIN_MAX);
        wr_time_ok   = wr_valid && (wr_target == 4'd0) && wr_fields_ok
                       && bcd_valid(wr_sec, SEC_MAX);
        wr_alarm_ok  = wr_valid && (wr_target != 4'd0) && (wr_target <= LAST_TARGET)
                       && wr_fields_ok;
        // a time write swallows a coincident tick, so nothing ticks off the loaded value
        tick_adv     = tick_1hz && !wr_time_ok;

        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        if (wr_time_ok) begin
            hour_d = wr_hour;
            min_d  = wr_min;
            sec_d  = wr_sec;
        end else if (tick_adv) begin
            sec_d = sec_inc.val;
            if (sec_inc.carry) begin
                min_d = min_inc.val;
                if (min_inc.carry) hour_d = hour_inc.val;
            end
        end

        top_of_hour = tick_adv && (min_d == 8'h00) && (sec_d == 8'h00);
        chime_cnt_d = chime_cnt_q;
        if (top_of_hour)
            chime_cnt_d = CHIME_LOAD;
        else if (tick_adv && (chime_cnt_q != '0))
            chime_cnt_d = chime_cnt_q - CHIME_W'(1);
    end

    assign day_wrap_unused = hour_inc.carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hour_q      <= 8'h00;
            min_q       <= 8'h00;
            sec_q       <= 8'h00;
            chime_cnt_q <= '0;
            wr_ack_q    <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            chime_cnt_q <= chime_cnt_d;
            wr_ack_q    <= wr_time_ok || wr_alarm_ok;
            wr_err_q    <= wr_valid && !(wr_time_ok || wr_alarm_ok);
        end
    end

    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_alarm
        alarm_channel #(
            .SNOOZE_MIN (SNOOZE_MIN),
            .RING_SECS  (RING_SECS)
        ) u_channel (
            .clk_i       (clk),
            .rst_i       (rst),
            .en_i        (alarm_en[g]),
            .wr_load_i   (wr_alarm_ok && (wr_target == 4'(g + 1))),
            .wr_hour_i   (wr_hour),
            .wr_min_i    (wr_min),
            .tick_i      (tick_adv),
            .next_hour_i (hour_d),
            .next_min_i  (min_d),
            .next_sec_i  (sec_d),
            .snooze_i    (snooze),
            .dismiss_i   (dismiss),
            .ringing_o   (ring_vec[g]),
            .snoozed_o   (snoozed[g])
        );
    end

    always_comb begin
        ring_id_c  = 4'd0;
        ring_found = 1'b0;
        for (int i = 0; i < int'(NUM_ALARMS); i++) begin
            if (ring_vec[i] && !ring_found) begin
                ring_id_c  = 4'(i);
                ring_found = 1'b1;
            end
        end
    end

    assign hour_bcd = hour_q;
    assign min_bcd  = min_q;
    assign sec_bcd  = sec_q;
    assign ringing  = |ring_vec;
    assign ring_id  = ring_id_c;
    assign chime    = (chime_cnt_q != '0) && !ringing;
    assign wr_ack   = wr_ack_q;
    assign wr_err   = wr_err_q;

endmodule
